// File: rtl/proc_pkg.sv
// Shared processor definitions for the register-file writeback path.
package proc_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = 2;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    // Two-way round-robin pick; result is one-hot {mem, alu}.
    function automatic logic [1:0] rr_pick(input logic alu_v, input logic mem_v, input grant_e last);
        logic [1:0] gnt;
        if (alu_v && mem_v) begin
            gnt = (last == GNT_MEM) ? 2'b01 : 2'b10;
        end else begin
            gnt = {mem_v, alu_v};
        end
        return gnt;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback, issue and hazard-check signals between the pipeline and regfile_wb_ctrl.
interface regfile_wb_ctrl_if #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
);
    logic              ALU_VALID;
    logic [ADDR_W-1:0] ALU_ADDR;
    logic [DATA_W-1:0] ALU_DATA;
    logic              ALU_READY;
    logic              MEM_VALID;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DATA;
    logic              MEM_READY;
    logic              RF_WRITE;
    logic [ADDR_W-1:0] RF_INADDRESS;
    logic [DATA_W-1:0] RF_INDATA;
    logic              ISSUE_VALID;
    logic [ADDR_W-1:0] ISSUE_ADDR;
    logic              ISSUE_READY;
    logic [ADDR_W-1:0] CHECK_ADDR1;
    logic [ADDR_W-1:0] CHECK_ADDR2;
    logic              HAZARD;
    logic              SB_ERR;

    modport master (
        output ALU_VALID, ALU_ADDR, ALU_DATA, MEM_VALID, MEM_ADDR, MEM_DATA,
               ISSUE_VALID, ISSUE_ADDR, CHECK_ADDR1, CHECK_ADDR2,
        input  ALU_READY, MEM_READY, RF_WRITE, RF_INADDRESS, RF_INDATA,
               ISSUE_READY, HAZARD, SB_ERR
    );

    modport slave (
        input  ALU_VALID, ALU_ADDR, ALU_DATA, MEM_VALID, MEM_ADDR, MEM_DATA,
               ISSUE_VALID, ISSUE_ADDR, CHECK_ADDR1, CHECK_ADDR2,
        output ALU_READY, MEM_READY, RF_WRITE, RF_INADDRESS, RF_INDATA,
               ISSUE_READY, HAZARD, SB_ERR
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the shared register-file write port.
module wb_rr_arbiter
    import proc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_alu_valid,
    input  logic       i_mem_valid,
    output logic       o_alu_ready,
    output logic       o_mem_ready,
    output logic [1:0] o_gnt
);

    grant_e     r_last_grant;
    logic [1:0] w_gnt;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        w_gnt = 2'b00;
        if (i_rst) begin
            w_gnt = 2'b00;
        end else begin
            w_gnt = rr_pick(i_alu_valid, i_mem_valid, r_last_grant);
        end
    end

    // Remember the most recent winner so the other source wins the next conflict.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= GNT_MEM;
        end else if (w_gnt[0]) begin
            r_last_grant <= GNT_ALU;
        end else if (w_gnt[1]) begin
            r_last_grant <= GNT_MEM;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign o_gnt       = w_gnt;
    assign o_alu_ready = w_gnt[0];
    assign o_mem_ready = w_gnt[1];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load writebacks onto the register file and tracks pending writes.
module regfile_wb_ctrl
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int CNT_W  = proc_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    regfile_wb_ctrl_if.slave  bus
);

    localparam int              NREGS   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        w_gnt;
    logic              w_alu_ready;
    logic              w_mem_ready;
    logic              w_alu_xfer;
    logic              w_mem_xfer;
    logic              w_issue_ready;
    logic              w_issue_fire;
    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_dec;
    logic [NREGS-1:0]  w_dec_at_zero;
    logic              r_rf_write;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic              r_sb_err;
    logic [CNT_W-1:0]  r_cnt [NREGS];

    wb_rr_arbiter u_arb (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_alu_valid (bus.ALU_VALID),
        .i_mem_valid (bus.MEM_VALID),
        .o_alu_ready (w_alu_ready),
        .o_mem_ready (w_mem_ready),
        .o_gnt       (w_gnt)
    );

    assign w_alu_xfer    = bus.ALU_VALID && w_alu_ready;
    assign w_mem_xfer    = bus.MEM_VALID && w_mem_ready;
    assign w_issue_ready = !RESET && (r_cnt[bus.ISSUE_ADDR] != CNT_MAX);
    assign w_issue_fire  = bus.ISSUE_VALID && w_issue_ready;

    // Output register feeding the register file write port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rf_write <= 1'b0;
            r_rf_addr  <= {ADDR_W{1'b0}};
            r_rf_data  <= {DATA_W{1'b0}};
        end else begin
            r_rf_write <= w_alu_xfer || w_mem_xfer;
            if (w_alu_xfer) begin
                r_rf_addr <= bus.ALU_ADDR;
                r_rf_data <= bus.ALU_DATA;
            end else if (w_mem_xfer) begin
                r_rf_addr <= bus.MEM_ADDR;
                r_rf_data <= bus.MEM_DATA;
            end else begin
                r_rf_addr <= r_rf_addr;
                r_rf_data <= r_rf_data;
            end
        end
    end

    // Per-register increment/decrement requests; the decrement tracks the write being presented now.
    always_comb begin
        w_inc         = {NREGS{1'b0}};
        w_dec         = {NREGS{1'b0}};
        w_dec_at_zero = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            w_inc[i]         = w_issue_fire && (bus.ISSUE_ADDR == ADDR_W'(i));
            w_dec[i]         = r_rf_write && (r_rf_addr == ADDR_W'(i));
            w_dec_at_zero[i] = w_dec[i] && (r_cnt[i] == {CNT_W{1'b0}});
        end
    end

    // Pending-write counters and the sticky underflow flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sb_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            r_sb_err <= r_sb_err || (|w_dec_at_zero);
            for (int i = 0; i < NREGS; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    2'b01:   r_cnt[i] <= (r_cnt[i] == {CNT_W{1'b0}}) ? r_cnt[i] : r_cnt[i] - CNT_ONE;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    assign bus.ALU_READY    = w_alu_ready;
    assign bus.MEM_READY    = w_mem_ready;
    assign bus.ISSUE_READY  = w_issue_ready;
    assign bus.RF_WRITE     = r_rf_write;
    assign bus.RF_INADDRESS = r_rf_addr;
    assign bus.RF_INDATA    = r_rf_data;
    assign bus.SB_ERR       = r_sb_err;
    assign bus.HAZARD       = (r_cnt[bus.CHECK_ADDR1] != {CNT_W{1'b0}}) ||
                              (r_cnt[bus.CHECK_ADDR2] != {CNT_W{1'b0}});

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    regfile_wb_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_wb_ctrl #(.DATA_W(8), .ADDR_W(3), .CNT_W(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.ALU_VALID = 1'b1; bus.MEM_VALID = 1'b1; bus.ISSUE_VALID = 1'b1;
        tick(); tick(); #1;
        total++; if (bus.ALU_READY !== 1'b0) begin $display("FAIL rst_alu_ready got=%b exp=0", bus.ALU_READY); bad++; end
        total++; if (bus.MEM_READY !== 1'b0) begin $display("FAIL rst_mem_ready got=%b exp=0", bus.MEM_READY); bad++; end
        total++; if (bus.ISSUE_READY !== 1'b0) begin $display("FAIL rst_issue_ready got=%b exp=0", bus.ISSUE_READY); bad++; end
        total++; if (bus.RF_WRITE !== 1'b0) begin $display("FAIL rst_rf_write got=%b exp=0", bus.RF_WRITE); bad++; end
        total++; if (bus.RF_INADDRESS !== 3'd0) begin $display("FAIL rst_rf_addr got=%0d exp=0", bus.RF_INADDRESS); bad++; end
        total++; if (bus.RF_INDATA !== 8'h00) begin $display("FAIL rst_rf_data got=%h exp=00", bus.RF_INDATA); bad++; end
        total++; if (bus.SB_ERR !== 1'b0) begin $display("FAIL rst_sb_err got=%b exp=0", bus.SB_ERR); bad++; end
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL rst_hazard got=%b exp=0", bus.HAZARD); bad++; end
        RESET = 1'b0;
        bus.ALU_VALID = 1'b0; bus.MEM_VALID = 1'b0; bus.ISSUE_VALID = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        logic [2:0] iss_addr [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        logic       exp_alu  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] exp_addr [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        logic [7:0] exp_data [4] = '{8'h11, 8'h21, 8'h12, 8'h22};
        for (int k = 0; k < 4; k++) begin
            bus.ISSUE_ADDR = iss_addr[k]; bus.ISSUE_VALID = 1'b1; #1;
            total++; if (bus.ISSUE_READY !== 1'b1) begin $display("FAIL cf_issue_ready[%0d] got=%b exp=1", k, bus.ISSUE_READY); bad++; end
            tick();
        end
        bus.ISSUE_VALID = 1'b0;
        bus.ALU_ADDR = 3'd1; bus.ALU_DATA = 8'h11; bus.ALU_VALID = 1'b1;
        bus.MEM_ADDR = 3'd2; bus.MEM_DATA = 8'h21; bus.MEM_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus.ALU_READY !== exp_alu[k]) begin $display("FAIL cf_alu_ready[%0d] got=%b exp=%b", k, bus.ALU_READY, exp_alu[k]); bad++; end
            total++; if (bus.MEM_READY !== !exp_alu[k]) begin $display("FAIL cf_mem_ready[%0d] got=%b exp=%b", k, bus.MEM_READY, !exp_alu[k]); bad++; end
            tick();
            total++; if (bus.RF_WRITE !== 1'b1) begin $display("FAIL cf_rf_write[%0d] got=%b exp=1", k, bus.RF_WRITE); bad++; end
            total++; if (bus.RF_INADDRESS !== exp_addr[k]) begin $display("FAIL cf_rf_addr[%0d] got=%0d exp=%0d", k, bus.RF_INADDRESS, exp_addr[k]); bad++; end
            total++; if (bus.RF_INDATA !== exp_data[k]) begin $display("FAIL cf_rf_data[%0d] got=%h exp=%h", k, bus.RF_INDATA, exp_data[k]); bad++; end
            if (exp_alu[k]) bus.ALU_DATA = bus.ALU_DATA + 8'h01;
            else            bus.MEM_DATA = bus.MEM_DATA + 8'h01;
        end
        bus.ALU_VALID = 1'b0; bus.MEM_VALID = 1'b0;
        bus.CHECK_ADDR1 = 3'd1; bus.CHECK_ADDR2 = 3'd2;
        tick();
        total++; if (bus.RF_WRITE !== 1'b0) begin $display("FAIL cf_idle_write got=%b exp=0", bus.RF_WRITE); bad++; end
        total++; if (bus.RF_INDATA !== 8'h22) begin $display("FAIL cf_hold_data got=%h exp=22", bus.RF_INDATA); bad++; end
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL cf_hazard got=%b exp=0", bus.HAZARD); bad++; end
        total++; if (bus.SB_ERR !== 1'b0) begin $display("FAIL cf_sb_err got=%b exp=0", bus.SB_ERR); bad++; end
    endtask

    task automatic test_single_alu();
        bus.CHECK_ADDR1 = 3'd3; bus.CHECK_ADDR2 = 3'd0;
        bus.ISSUE_ADDR = 3'd3; bus.ISSUE_VALID = 1'b1;
        tick();
        bus.ISSUE_VALID = 1'b0; #1;
        total++; if (bus.HAZARD !== 1'b1) begin $display("FAIL sa_hazard_set got=%b exp=1", bus.HAZARD); bad++; end
        bus.ALU_ADDR = 3'd3; bus.ALU_DATA = 8'h5A; bus.ALU_VALID = 1'b1; #1;
        total++; if (bus.ALU_READY !== 1'b1) begin $display("FAIL sa_alu_ready got=%b exp=1", bus.ALU_READY); bad++; end
        total++; if (bus.MEM_READY !== 1'b0) begin $display("FAIL sa_mem_ready got=%b exp=0", bus.MEM_READY); bad++; end
        tick();
        bus.ALU_VALID = 1'b0; #1;
        total++; if (bus.RF_WRITE !== 1'b1) begin $display("FAIL sa_rf_write got=%b exp=1", bus.RF_WRITE); bad++; end
        total++; if (bus.RF_INADDRESS !== 3'd3) begin $display("FAIL sa_rf_addr got=%0d exp=3", bus.RF_INADDRESS); bad++; end
        total++; if (bus.RF_INDATA !== 8'h5A) begin $display("FAIL sa_rf_data got=%h exp=5a", bus.RF_INDATA); bad++; end
        total++; if (bus.HAZARD !== 1'b1) begin $display("FAIL sa_hazard_during got=%b exp=1", bus.HAZARD); bad++; end
        tick();
        total++; if (bus.RF_WRITE !== 1'b0) begin $display("FAIL sa_rf_write_after got=%b exp=0", bus.RF_WRITE); bad++; end
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL sa_hazard_clear got=%b exp=0", bus.HAZARD); bad++; end
    endtask

    task automatic test_hazard();
        bus.ISSUE_ADDR = 3'd5; bus.ISSUE_VALID = 1'b1;
        bus.CHECK_ADDR1 = 3'd5; bus.CHECK_ADDR2 = 3'd0;
        tick();
        bus.ISSUE_VALID = 1'b0;
        tick(); tick();
        total++; if (bus.HAZARD !== 1'b1) begin $display("FAIL hz_pending got=%b exp=1", bus.HAZARD); bad++; end
        bus.MEM_ADDR = 3'd5; bus.MEM_DATA = 8'h77; bus.MEM_VALID = 1'b1; #1;
        total++; if (bus.MEM_READY !== 1'b1) begin $display("FAIL hz_mem_ready got=%b exp=1", bus.MEM_READY); bad++; end
        tick();
        bus.MEM_VALID = 1'b0;
        total++; if (bus.RF_INDATA !== 8'h77) begin $display("FAIL hz_rf_data got=%h exp=77", bus.RF_INDATA); bad++; end
        total++; if (bus.HAZARD !== 1'b1) begin $display("FAIL hz_before_commit got=%b exp=1", bus.HAZARD); bad++; end
        tick();
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL hz_after_commit got=%b exp=0", bus.HAZARD); bad++; end
    endtask

    task automatic test_saturation();
        bus.ISSUE_ADDR = 3'd2; bus.ISSUE_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.ISSUE_READY !== 1'b1) begin $display("FAIL sat_ready[%0d] got=%b exp=1", k, bus.ISSUE_READY); bad++; end
            tick();
        end
        total++; if (bus.ISSUE_READY !== 1'b0) begin $display("FAIL sat_full got=%b exp=0", bus.ISSUE_READY); bad++; end
        tick();
        bus.ISSUE_VALID = 1'b0;
        bus.ALU_ADDR = 3'd2; bus.ALU_DATA = 8'h33; bus.ALU_VALID = 1'b1;
        tick();
        bus.ALU_VALID = 1'b0; #1;
        total++; if (bus.ISSUE_READY !== 1'b0) begin $display("FAIL sat_full_during_commit got=%b exp=0", bus.ISSUE_READY); bad++; end
        tick();
        total++; if (bus.ISSUE_READY !== 1'b1) begin $display("FAIL sat_after_commit got=%b exp=1", bus.ISSUE_READY); bad++; end
    endtask

    task automatic test_sim_issue_commit();
        bus.CHECK_ADDR1 = 3'd4; bus.CHECK_ADDR2 = 3'd4;
        bus.ISSUE_ADDR = 3'd4; bus.ISSUE_VALID = 1'b1;
        tick();
        bus.ISSUE_VALID = 1'b0;
        bus.ALU_ADDR = 3'd4; bus.ALU_DATA = 8'h44; bus.ALU_VALID = 1'b1;
        tick();
        bus.ALU_VALID = 1'b0; bus.ISSUE_VALID = 1'b1; #1;
        total++; if (bus.ISSUE_READY !== 1'b1) begin $display("FAIL sim_issue_ready got=%b exp=1", bus.ISSUE_READY); bad++; end
        tick();
        bus.ISSUE_VALID = 1'b0; #1;
        total++; if (bus.HAZARD !== 1'b1) begin $display("FAIL sim_hazard_held got=%b exp=1", bus.HAZARD); bad++; end
        bus.ALU_DATA = 8'h45; bus.ALU_VALID = 1'b1;
        tick();
        bus.ALU_VALID = 1'b0;
        tick();
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL sim_count_was_one got=%b exp=0", bus.HAZARD); bad++; end
        total++; if (bus.SB_ERR !== 1'b0) begin $display("FAIL sim_sb_err got=%b exp=0", bus.SB_ERR); bad++; end
        bus.ALU_ADDR = 3'd6; bus.ALU_DATA = 8'h66; bus.ALU_VALID = 1'b1;
        tick();
        bus.ALU_VALID = 1'b0; #1;
        total++; if (bus.SB_ERR !== 1'b0) begin $display("FAIL err_early got=%b exp=0", bus.SB_ERR); bad++; end
        tick();
        total++; if (bus.SB_ERR !== 1'b1) begin $display("FAIL err_set got=%b exp=1", bus.SB_ERR); bad++; end
        tick(); tick();
        bus.CHECK_ADDR1 = 3'd6; #1;
        total++; if (bus.SB_ERR !== 1'b1) begin $display("FAIL err_sticky got=%b exp=1", bus.SB_ERR); bad++; end
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL err_cnt_zero got=%b exp=0", bus.HAZARD); bad++; end
    endtask

    task automatic test_mid_reset();
        bus.CHECK_ADDR1 = 3'd2; bus.CHECK_ADDR2 = 3'd2; #1;
        total++; if (bus.HAZARD !== 1'b1) begin $display("FAIL mr_pre_hazard got=%b exp=1", bus.HAZARD); bad++; end
        RESET = 1'b1;
        bus.ALU_ADDR = 3'd0; bus.ALU_DATA = 8'hA0; bus.ALU_VALID = 1'b1;
        bus.MEM_ADDR = 3'd1; bus.MEM_DATA = 8'hB0; bus.MEM_VALID = 1'b1;
        bus.ISSUE_ADDR = 3'd0; bus.ISSUE_VALID = 1'b1; #1;
        total++; if (bus.ALU_READY !== 1'b0) begin $display("FAIL mr_alu_ready got=%b exp=0", bus.ALU_READY); bad++; end
        total++; if (bus.MEM_READY !== 1'b0) begin $display("FAIL mr_mem_ready got=%b exp=0", bus.MEM_READY); bad++; end
        total++; if (bus.ISSUE_READY !== 1'b0) begin $display("FAIL mr_issue_ready got=%b exp=0", bus.ISSUE_READY); bad++; end
        tick();
        total++; if (bus.RF_WRITE !== 1'b0) begin $display("FAIL mr_rf_write got=%b exp=0", bus.RF_WRITE); bad++; end
        total++; if (bus.HAZARD !== 1'b0) begin $display("FAIL mr_hazard got=%b exp=0", bus.HAZARD); bad++; end
        total++; if (bus.SB_ERR !== 1'b0) begin $display("FAIL mr_sb_err got=%b exp=0", bus.SB_ERR); bad++; end
        RESET = 1'b0; bus.ISSUE_VALID = 1'b0; #1;
        total++; if (bus.ALU_READY !== 1'b1) begin $display("FAIL mr_alu_first got=%b exp=1", bus.ALU_READY); bad++; end
        total++; if (bus.MEM_READY !== 1'b0) begin $display("FAIL mr_mem_second got=%b exp=0", bus.MEM_READY); bad++; end
        tick();
        bus.ALU_VALID = 1'b0; bus.MEM_VALID = 1'b0;
        total++; if (bus.RF_INDATA !== 8'hA0) begin $display("FAIL mr_rf_data got=%h exp=a0", bus.RF_INDATA); bad++; end
    endtask

    initial begin
        total = 0; bad = 0;
        RESET = 1'b1;
        bus.ALU_VALID = 1'b0; bus.ALU_ADDR = 3'd0; bus.ALU_DATA = 8'h00;
        bus.MEM_VALID = 1'b0; bus.MEM_ADDR = 3'd0; bus.MEM_DATA = 8'h00;
        bus.ISSUE_VALID = 1'b0; bus.ISSUE_ADDR = 3'd0;
        bus.CHECK_ADDR1 = 3'd0; bus.CHECK_ADDR2 = 3'd0;
        test_reset();
        test_conflict();
        test_single_alu();
        test_hazard();
        test_saturation();
        test_sim_issue_commit();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
